// File: rtl/displ_pkg.sv
// Shared constants for the multiplexed 7-segment display: defaults, segment bit map, glyphs.
// Latency: n/a (package only).
// Backpressure: n/a.
package displ_pkg;

  localparam int N_DIG_DEF   = 4;
  localparam int DIV_W_DEF   = 10;
  localparam int BLINK_W_DEF = 5;

  // Segment bit positions on the seg bus (active-high)
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Hex glyph table, bit order g..a (bit 6 = g, bit 0 = a)
  function automatic logic [6:0] glyph_of(input logic [3:0] nib);
    logic [6:0] g;
    g = 7'h00;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to 7-segment glyph decode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module seg_decode
  import displ_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup of the glyph for the selected nibble
  always_comb begin
    seg = glyph_of(nib);
  end

endmodule

// File: rtl/displ_ndig_mux.sv
// N-digit time-multiplexed 7-segment driver with brightness PWM, blink and leading-zero blanking.
// Latency: dig/seg registered, one clk behind the slot/index state.
// Backpressure: none; en=0 freezes all state and blanks the outputs.
module displ_ndig_mux
  import displ_pkg::*;
#(
  parameter int N_DIG   = N_DIG_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BLINK_W = BLINK_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [4*N_DIG-1:0] number,
  input  logic [N_DIG-1:0]   dp,
  input  logic               blank_lz,
  input  logic [2:0]         bright,
  input  logic [N_DIG-1:0]   blink,
  output logic [N_DIG-1:0]   dig,
  output logic [7:0]         seg,
  output logic               frame_tick
);

  localparam int IDX_W = $clog2(N_DIG);

  logic [DIV_W-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [4*N_DIG-1:0] num_q, num_d;
  logic [N_DIG-1:0]   dp_sh_q, dp_sh_d;
  logic [N_DIG-1:0]   blink_sh_q, blink_sh_d;
  logic [BLINK_W-1:0] fcnt_q, fcnt_d;
  logic               phase_q, phase_d;
  logic [N_DIG-1:0]   dig_q, dig_d;
  logic [7:0]         seg_q, seg_d;
  logic               tick_q, tick_d;

  logic               slot_wrap, idx_last, frame_wrap;
  logic               pwm_on, blanked, upper_zero;
  logic [N_DIG-1:0]   lz_mask;
  logic [3:0]         cur_nib;
  logic [6:0]         cur_glyph;

  assign slot_wrap  = (slot_q == {DIV_W{1'b1}});
  assign idx_last   = (idx_q == IDX_W'(N_DIG - 1));
  assign frame_wrap = slot_wrap && idx_last;
  assign cur_nib    = num_q[{idx_q, 2'b00} +: 4];
  assign pwm_on     = (slot_q[DIV_W-1 -: 3] <= bright);

  seg_decode u_seg_decode (
    .nib (cur_nib),
    .seg (cur_glyph)
  );

  // Leading-zero mask: digit k blanks when it and every higher shadow nibble are zero
  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (num_q[4*k +: 4] == 4'h0);
      lz_mask[k] = upper_zero;
    end
  end

  // Counter, index, shadow capture and blink phase advance
  always_comb begin
    slot_d     = slot_q;
    idx_d      = idx_q;
    num_d      = num_q;
    dp_sh_d    = dp_sh_q;
    blink_sh_d = blink_sh_q;
    fcnt_d     = fcnt_q;
    phase_d    = phase_q;
    tick_d     = 1'b0;
    if (en) begin
      slot_d = slot_q + DIV_W'(1);
      if (slot_wrap) begin
        idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
      end
      if (frame_wrap) begin
        num_d      = number;
        dp_sh_d    = dp;
        blink_sh_d = blink;
        fcnt_d     = fcnt_q + BLINK_W'(1);
        tick_d     = 1'b1;
        if (fcnt_q == {BLINK_W{1'b1}}) begin
          phase_d = ~phase_q;
        end
      end
    end
  end

  // Output drive for the current slot: PWM gate, then blink / leading-zero blanking
  always_comb begin
    blanked = (blank_lz && lz_mask[idx_q]) || (phase_q && blink_sh_q[idx_q]);
    dig_d   = '0;
    seg_d   = '0;
    if (en && pwm_on) begin
      dig_d = N_DIG'(1) << idx_q;
      if (!blanked) begin
        seg_d[SEG_G:SEG_A] = cur_glyph;
        seg_d[SEG_DP]      = dp_sh_q[idx_q];
      end
    end
  end

  // State and output registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q     <= '0;
      idx_q      <= '0;
      num_q      <= '0;
      dp_sh_q    <= '0;
      blink_sh_q <= '0;
      fcnt_q     <= '0;
      phase_q    <= 1'b0;
      dig_q      <= '0;
      seg_q      <= '0;
      tick_q     <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
      dp_sh_q    <= dp_sh_d;
      blink_sh_q <= blink_sh_d;
      fcnt_q     <= fcnt_d;
      phase_q    <= phase_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
      tick_q     <= tick_d;
    end
  end

  assign dig        = dig_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_displ_ndig_mux.sv
// Self-checking bench for displ_ndig_mux: arithmetic reference model feeding a scoreboard queue.
// Latency: expected value for each edge is queued before the edge and compared 1 ns after it.
// Backpressure: n/a.
module tb_displ_ndig_mux;

  localparam int N_DIG   = 4;
  localparam int DIV_W   = 3;
  localparam int BLINK_W = 1;
  localparam int SLOT    = 1 << DIV_W;
  localparam int FRAME   = SLOT * N_DIG;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] number;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [2:0]  bright;
  logic [3:0]  blink;
  logic [3:0]  dig;
  logic [7:0]  seg;
  logic        frame_tick;

  always #5 clk = ~clk;

  displ_ndig_mux #(
    .N_DIG   (N_DIG),
    .DIV_W   (DIV_W),
    .BLINK_W (BLINK_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .number     (number),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .bright     (bright),
    .blink      (blink),
    .dig        (dig),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] seg;
    logic       tick;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state: count of enabled cycles since reset plus captured shadows
  int          n;
  logic [15:0] sh_num;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_blink;

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected registered outputs after the coming edge, from current inputs and model state
  function automatic exp_t model_out();
    exp_t        e;
    int          slot, idx, frame;
    bit          phase, lz, bl;
    logic [15:0] upper;
    logic [3:0]  nib;
    e = '0;
    if (rst || !en) return e;
    slot   = n % SLOT;
    idx    = (n / SLOT) % N_DIG;
    frame  = n / FRAME;
    phase  = ((frame >> BLINK_W) % 2) == 1;
    e.tick = (n % FRAME) == FRAME - 1;
    upper  = sh_num >> (4 * idx);
    nib    = upper[3:0];
    lz     = blank_lz && (idx > 0) && (upper == 16'h0);
    bl     = phase && sh_blink[idx];
    if ((slot >> (DIV_W - 3)) <= int'(bright)) begin
      e.dig = 4'(1 << idx);
      if (!lz && !bl) e.seg = {sh_dp[idx], ref_glyph(nib)};
    end
    return e;
  endfunction

  // Run k clock cycles with the current inputs, scoreboarding every edge
  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      sb.push_back(model_out());
      if (rst) begin
        n = 0; sh_num = '0; sh_dp = '0; sh_blink = '0;
      end else if (en) begin
        if (n % FRAME == FRAME - 1) begin
          sh_num = number; sh_dp = dp; sh_blink = blink;
        end
        n++;
      end
      @(posedge clk);
      #1;
      check("sb_level", sb.size(), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("dig", dig, e.dig);
        check("seg", seg, e.seg);
        check("tick", frame_tick, e.tick);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; number = '0; dp = '0; blank_lz = 1'b0;
    bright = 3'd7; blink = '0;
    n = 0; sh_num = '0; sh_dp = '0; sh_blink = '0;
    @(negedge clk);
    cyc(2);
    rst = 1'b0;

    // Basic walk, full brightness
    en = 1'b1; number = 16'h1234;
    cyc(3 * FRAME);

    // Leading-zero blanking
    number = 16'h0042; blank_lz = 1'b1;
    cyc(2 * FRAME);
    number = 16'h0000;
    cyc(2 * FRAME);

    // Brightness PWM
    blank_lz = 1'b0; number = 16'h1234; bright = 3'd0;
    cyc(2 * FRAME);
    bright = 3'd3;
    cyc(2 * FRAME);

    // Blink on digit 0 and decimal point on digit 2
    bright = 3'd7; blink = 4'b0001; dp = 4'b0100;
    cyc(8 * FRAME);
    blink = '0; dp = '0;

    // Mid-frame number changes, covering the remaining glyphs
    cyc(10);
    number = 16'hABCD;
    cyc(20);
    number = 16'h5678;
    cyc(FRAME + 13);
    number = 16'h9EF0;
    cyc(FRAME + 3);

    // Freeze mid-slot, then resume
    en = 1'b0;
    cyc(5);
    en = 1'b1;
    cyc(FRAME);

    // Asynchronous reset mid-slot
    cyc(5);
    rst = 1'b1;
    #1;
    check("rst_async_dig", dig, 0);
    check("rst_async_seg", seg, 0);
    check("rst_async_tick", frame_tick, 0);
    @(negedge clk);
    cyc(2);
    rst = 1'b0;
    cyc(FRAME + 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/displ_ndig_mux.md
DISPL_NDIG_MUX -- requirements
Module: displ_ndig_mux

Interface
REQ-001 Parameter N_DIG, default 4, number of multiplexed digits, legal range 2..8.
REQ-002 Parameter DIV_W, default 10, digit slot length = 2^DIV_W clk cycles, legal range 3..16.
REQ-003 Parameter BLINK_W, default 5, blink half-period = 2^BLINK_W frames.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  run enable; 0 freezes all counters and blanks outputs.
REQ-007 number  in  4*N_DIG  hex nibbles; nibble k drives digit k, digit 0 = least significant.
REQ-008 dp  in  N_DIG  decimal point per digit.
REQ-009 blank_lz  in  1  leading-zero blanking enable.
REQ-010 bright  in  3  brightness, 0 = 1/8 duty, 7 = full duty.
REQ-011 blink  in  N_DIG  per-digit blink enable.
REQ-012 dig  out  N_DIG  one-hot digit select, active-high.
REQ-013 seg  out  8  segments a..g on [6:0], dp on [7], active-high.
REQ-014 frame_tick  out  1  single-cycle pulse at the start of each frame.

Function
REQ-015 The slot counter (DIV_W bits) SHALL increment on every clk with en=1 and wrap from 2^DIV_W-1 to 0.
REQ-016 On the slot-counter wrap, the digit index SHALL advance by 1, wrapping from N_DIG-1 to 0.
REQ-017 On the index wrap to 0, number, dp and blink SHALL be captured into shadow registers, and all digits of one frame SHALL use the shadow values.
REQ-018 frame_tick SHALL be 1 for exactly the clk cycle following the index wrap to 0.
REQ-019 dig and seg SHALL be registered and SHALL reflect a new index one clk after the slot-counter wrap.
REQ-020 Within a slot, dig SHALL be driven only while the top 3 bits of the slot counter are <= bright; otherwise dig = 0 and seg = 0.
REQ-021 The blink phase SHALL toggle every 2^BLINK_W frames; while phase=1, digits with shadow blink set SHALL be blanked.
REQ-022 With blank_lz=1, digit k>0 SHALL be blanked when shadow nibbles N_DIG-1..k are all zero; digit 0 SHALL never be blanked by this rule.
REQ-023 A blanked digit SHALL drive seg = 0; its dp SHALL also be suppressed, while dig stays one-hot.
REQ-024 While en=0, counters, index, shadows and blink phase SHALL hold, with dig = 0, seg = 0 and frame_tick = 0; on the return to en=1, operation SHALL resume from the held state.
REQ-025 Nibble decoding SHALL cover 0..F (hex glyphs A,b,C,d,E,F).

Reset
REQ-026 Asserting rst SHALL immediately force dig=0, seg=0, frame_tick=0, slot counter 0, index 0, blink phase 0 and shadows 0.
REQ-027 After rst deasserts, the first frame SHALL begin with the index at 0, and shadow capture SHALL occur at the first index wrap.
REQ-028 An rst asserted mid-slot SHALL abort the slot without producing a partial frame_tick.

Structure
REQ-029 The 7-segment glyph table, the segment bit positions and the default parameter values SHALL live in a shared package displ_pkg.
REQ-030 The combinational nibble-to-segment decode SHALL be a sub-module seg_decode (nibble in, 7 bits out), instanced once.
REQ-031 The top-level module SHALL hold the counters, shadows, blink/blanking logic and output registers.

Verification (N_DIG=4, DIV_W=3, BLINK_W=1)
REQ-032 rst pulse, en=1, number=16'h1234, bright=7 -> dig walks 0001,0010,0100,1000 every 8 clk; seg=4,3,2,1 glyphs; frame_tick every 32 clk.
REQ-033 number=16'h0042, blank_lz=1 -> digits 3,2 give seg=0; digit 1 shows 4 and digit 0 shows 2; number=0 -> only digit 0 shows 0.
REQ-034 bright=0 -> dig active 1 of every 8 clk per slot; bright=3 -> active 4 of 8.
REQ-035 blink=4'b0001 -> digit 0 is blanked for 2 frames, then shown for 2 frames, repeating; dp=4'b0100 -> seg[7]=1 only in slot 2.
REQ-036 Change number mid-frame -> the display holds the old value until the next frame_tick; en=0 for 5 clk mid-slot -> outputs are 0, and on resume the slot completes its remaining cycles.
REQ-037 rst asserted mid-slot -> outputs are 0 asynchronously, and after release the sequence restarts at dig=0001.
